count_stream_monitor: RTL and testbench

- Receiving end of the 4-bit binary counter interface (count value plus enable). Samples the counter's enable and count every cycle, predicts the next count, and flags deviations.
- Counts wraps and errors, with saturating statistics.
- Resynchronises after a fault and reports lock status.
- Sits beside the counter in the same clock domain as an on-chip health monitor.

---
 rtl/count_stream_monitor.sv | 150 +++++++++++++++
 tb/tb_count_stream_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_stream_monitor.sv
// count_stream_monitor
//   Health monitor for a free-running binary counter in the same clock domain.
//   Each cycle it predicts the counter value from the previous sample
//   (prev_q + prev_en, natural wrap), flags deviations, credits verified
//   max->0 wraps, and resynchronises after a fault once RESYNC_LEN
//   consecutive consistent transitions have been seen.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   SYNC  | first sample after reset; counter must read zero
//   TRACK | locked; every sample checked against the prediction
//   FAULT | prediction rebases on every sample; counting clean transitions
//
// Ports:
//   clk          rising-edge clock shared with the counter
//   reset        synchronous active-high reset
//   cnt_en       counter enable as driven into the counter
//   cnt_q        counter output (WIDTH bits)
//   clr_stats    synchronous clear of err_count, wrap_count, err_sticky
//   locked       high while in TRACK
//   err_pulse    one-cycle pulse per detected mismatch
//   err_sticky   set on any mismatch until reset/clr_stats
//   err_count    saturating mismatch count (ERR_W bits)
//   wrap_pulse   one-cycle pulse per verified max->0 transition
//   wrap_count   saturating verified-wrap count (WRAP_W bits)
//   expected     registered prediction for the current cnt_q
module count_stream_monitor #(
    parameter int WIDTH      = 4,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 8,
    parameter int RESYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_en,
    input  logic [WIDTH-1:0]  cnt_q,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  expected
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0] RESYNC_LAST = 4'(RESYNC_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev_q;
    logic             prev_en;
    logic [3:0]       resync_cnt;
    logic [3:0]       resync_nxt;

    logic              match;
    logic              err_hit;
    logic              wrap_hit;
    logic [ERR_W-1:0]  err_base;
    logic [WRAP_W-1:0] wrap_base;

    always_comb begin
        match      = (cnt_q == expected);
        err_hit    = 1'b0;
        wrap_hit   = 1'b0;
        state_nxt  = state;
        resync_nxt = resync_cnt;
        case (state)
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_TRACK;
                end else begin
                    err_hit    = 1'b1;
                    state_nxt  = ST_FAULT;
                    resync_nxt = '0;
                end
            end
            ST_TRACK: begin
                if (match) begin
                    // A match with prev at max and enabled can only mean cnt_q == 0.
                    wrap_hit = prev_en && (&prev_q);
                end else begin
                    err_hit    = 1'b1;
                    state_nxt  = ST_FAULT;
                    resync_nxt = '0;
                end
            end
            ST_FAULT: begin
                if (!match) begin
                    err_hit    = 1'b1;
                    resync_nxt = '0;
                end else if (resync_cnt == RESYNC_LAST) begin
                    state_nxt  = ST_TRACK;
                    resync_nxt = '0;
                end else begin
                    resync_nxt = resync_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt  = ST_SYNC;
                resync_nxt = '0;
            end
        endcase

        // Clear is applied first so a same-cycle event still lands at 1.
        err_base  = clr_stats ? '0 : err_count;
        wrap_base = clr_stats ? '0 : wrap_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SYNC;
            prev_q     <= '0;
            prev_en    <= 1'b0;
            resync_cnt <= '0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            resync_cnt <= resync_nxt;
            prev_q     <= cnt_q;
            prev_en    <= cnt_en;
            expected   <= cnt_q + {{(WIDTH-1){1'b0}}, cnt_en};
            locked     <= (state_nxt == ST_TRACK);
            err_pulse  <= err_hit;
            wrap_pulse <= wrap_hit;
            err_sticky <= (clr_stats ? 1'b0 : err_sticky) | err_hit;
            if (err_hit && !(&err_base))
                err_count <= err_base + 1'b1;
            else
                err_count <= err_base;
            if (wrap_hit && !(&wrap_base))
                wrap_count <= wrap_base + 1'b1;
            else
                wrap_count <= wrap_base;
        end
    end

endmodule

// File: tb/tb_count_stream_monitor.sv
module tb_count_stream_monitor;

    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cnt_en = 1'b0;
    logic [3:0] cnt_q = 4'd0;
    logic       clr_stats = 1'b0;

    logic       locked, err_pulse, err_sticky, wrap_pulse;
    logic [7:0] err_count, wrap_count;
    logic [3:0] expected;

    logic       locked2, err_pulse2, err_sticky2, wrap_pulse2;
    logic [1:0] err_count2;
    logic [7:0] wrap_count2;
    logic [3:0] expected2;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state (mode: 0 sync, 1 locked, 2 faulted)
    int m_mode, m_lq, m_len, m_rc, m_errc, m_wrapc;
    bit m_sticky, m_errp, m_wrapp;

    always #5 clk = ~clk;

    count_stream_monitor #(.WIDTH(4), .ERR_W(8), .WRAP_W(8), .RESYNC_LEN(RL)) dut (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .cnt_q(cnt_q), .clr_stats(clr_stats),
        .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
        .expected(expected)
    );

    count_stream_monitor #(.WIDTH(4), .ERR_W(2), .WRAP_W(8), .RESYNC_LEN(RL)) dut_e2 (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .cnt_q(cnt_q), .clr_stats(clr_stats),
        .locked(locked2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
        .err_count(err_count2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2),
        .expected(expected2)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic cycle(input bit r, input int q, input bit en, input bit clr);
        int pred;
        bit e, w;
        reset     = r;
        cnt_q     = q[3:0];
        cnt_en    = en;
        clr_stats = clr;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0; m_lq = 0; m_len = 0; m_rc = 0;
            m_errc = 0; m_wrapc = 0; m_sticky = 0; m_errp = 0; m_wrapp = 0;
        end else begin
            pred = (m_mode == 0) ? 0 : (m_lq + m_len) % 16;
            e = 0;
            w = 0;
            if (m_mode == 0) begin
                if (q == pred) m_mode = 1;
                else begin e = 1; m_mode = 2; m_rc = 0; end
            end else if (m_mode == 1) begin
                if (q == pred) w = (m_lq == 15) && (m_len == 1) && (q == 0);
                else begin e = 1; m_mode = 2; m_rc = 0; end
            end else begin
                if (q == pred) begin
                    m_rc++;
                    if (m_rc == RL) begin m_mode = 1; m_rc = 0; end
                end else begin
                    m_rc = 0;
                    e = 1;
                end
            end
            m_errc   = clr ? int'(e) : m_errc + int'(e);
            m_wrapc  = clr ? int'(w) : m_wrapc + int'(w);
            m_sticky = (clr ? 1'b0 : m_sticky) | e;
            m_errp   = e;
            m_wrapp  = w;
            m_lq     = q;
            m_len    = en;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        n_cmp++;
        if ({locked, err_pulse, err_sticky, wrap_pulse} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {locked, err_pulse, err_sticky, wrap_pulse});
        end
        n_cmp++;
        if ({err_count, wrap_count, expected} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_counts: got err=%0d wrap=%0d exp=%0d want 0", err_count, wrap_count, expected);
        end
    endtask

    task automatic test_count_wrap();
        int wraps = 0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, i % 16, 1, 0);
            if (wrap_pulse === 1'b1) wraps++;
            n_cmp++;
            if (locked !== 1'b1) begin
                n_bad++;
                $display("FAIL count_locked: cycle %0d got %b want 1", i, locked);
            end
        end
        n_cmp++;
        if (wraps != 1) begin n_bad++; $display("FAIL wrap_pulses: got %0d want 1", wraps); end
        n_cmp++;
        if (wrap_count !== 8'd1) begin n_bad++; $display("FAIL wrap_count: got %0d want 1", wrap_count); end
        n_cmp++;
        if (err_count !== 8'd0) begin n_bad++; $display("FAIL count_err: got %0d want 0", err_count); end
    endtask

    task automatic test_hold_fault();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, i, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 5, 0, 0);
            n_cmp++;
            if (err_pulse !== 1'b0 || locked !== 1'b1) begin
                n_bad++;
                $display("FAIL hold: got err_pulse=%b locked=%b want 0/1", err_pulse, locked);
            end
        end
        cycle(0, 7, 1, 0);
        n_cmp++;
        if ({err_pulse, err_sticky, locked} !== 3'b110 || err_count !== 8'd1) begin
            n_bad++;
            $display("FAIL hold_jump: got p/s/l=%b%b%b cnt=%0d want 110 cnt=1", err_pulse, err_sticky, locked, err_count);
        end
        cycle(0, 8, 1, 0);
        n_cmp++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_1: got locked=%b err_pulse=%b want 0/0", locked, err_pulse);
        end
        cycle(0, 9, 1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL resync_lock: got %b want 1", locked); end
        // second fault, glitch mid-resync, then lock across a 15->0 that must not be credited
        cycle(0, 13, 1, 0);
        cycle(0, 14, 1, 0);
        cycle(0, 2, 1, 0);
        n_cmp++;
        if (err_count !== 8'd3 || err_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch: got cnt=%0d pulse=%b want 3/1", err_count, err_pulse);
        end
        cycle(0, 14, 1, 0);
        cycle(0, 15, 1, 0);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL glitch_restart: got locked=%b want 0", locked); end
        cycle(0, 0, 1, 0);
        n_cmp++;
        if (locked !== 1'b1 || wrap_pulse !== 1'b0 || wrap_count !== 8'd0) begin
            n_bad++;
            $display("FAIL fault_wrap: got l=%b wp=%b wc=%0d want 1/0/0", locked, wrap_pulse, wrap_count);
        end
    endtask

    task automatic test_sync_error();
        cycle(1, 0, 0, 0);
        cycle(0, 3, 1, 0);
        n_cmp++;
        if (err_count !== 8'd1 || locked !== 1'b0 || err_pulse !== 1'b1 || wrap_count !== 8'd0) begin
            n_bad++;
            $display("FAIL sync_err: got cnt=%0d l=%b p=%b wc=%0d want 1/0/1/0", err_count, locked, err_pulse, wrap_count);
        end
        n_cmp++;
        if (expected !== 4'd4) begin n_bad++; $display("FAIL sync_rebase: got %0d want 4", expected); end
    endtask

    task automatic test_saturate_clear();
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cycle(0, 3 * i, 0, 0);
        n_cmp++;
        if (err_count2 !== 2'd3 || err_count !== 8'd5) begin
            n_bad++;
            $display("FAIL saturate: got e2=%0d e8=%0d want 3/5", err_count2, err_count);
        end
        cycle(0, 15, 0, 1);
        n_cmp++;
        if (err_count2 !== 2'd0 || err_sticky !== 1'b0 || err_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_alone: got e2=%0d sticky=%b pulse=%b want 0/0/0", err_count2, err_sticky, err_pulse);
        end
        cycle(0, 2, 0, 1);
        n_cmp++;
        if (err_count2 !== 2'd1 || err_count !== 8'd1 || err_sticky !== 1'b1 || err_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_err: got e2=%0d e8=%0d s=%b p=%b want 1/1/1/1", err_count2, err_count, err_sticky, err_pulse);
        end
    endtask

    task automatic test_reset_mid_fault();
        cycle(1, 0, 0, 0);
        cycle(0, 3, 0, 0);
        cycle(0, 9, 0, 0);
        n_cmp++;
        if (err_count !== 8'd2 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_reset: got cnt=%0d locked=%b want 2/0", err_count, locked);
        end
        cycle(1, 10, 1, 0);
        n_cmp++;
        if ({locked, err_pulse, err_sticky, wrap_pulse, err_count, wrap_count, expected} !== 24'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got l=%b p=%b s=%b wp=%b e=%0d w=%0d x=%0d want all 0",
                     locked, err_pulse, err_sticky, wrap_pulse, err_count, wrap_count, expected);
        end
        for (int i = 0; i < 3; i++) cycle(0, i, 1, 0);
        n_cmp++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL restart: got locked=%b cnt=%0d want 1/0", locked, err_count);
        end
    endtask

    task automatic test_random();
        int c = 0;
        int q;
        bit en, clr, r;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 79) == 0);
            clr = ($urandom_range(0, 15) == 0);
            en  = $urandom_range(0, 2) != 0;
            q   = c;
            if ($urandom_range(0, 11) == 0) q = (c + $urandom_range(1, 15)) % 16;
            cycle(r, q, en, clr);
            c = r ? 0 : (q + int'(en)) % 16;
            n_cmp++;
            if (locked !== (m_mode == 1) || err_pulse !== m_errp || wrap_pulse !== m_wrapp) begin
                n_bad++;
                $display("FAIL rnd_flags @%0d: got l=%b p=%b wp=%b want %b/%b/%b",
                         i, locked, err_pulse, wrap_pulse, m_mode == 1, m_errp, m_wrapp);
            end
            n_cmp++;
            if (err_sticky !== m_sticky || expected !== 4'(r ? 0 : (m_lq + m_len) % 16)) begin
                n_bad++;
                $display("FAIL rnd_sticky_exp @%0d: got s=%b x=%0d want %b/%0d",
                         i, err_sticky, expected, m_sticky, (m_lq + m_len) % 16);
            end
            n_cmp++;
            if (err_count !== 8'(sat(m_errc, 255)) || err_count2 !== 2'(sat(m_errc, 3))
                || wrap_count !== 8'(sat(m_wrapc, 255))) begin
                n_bad++;
                $display("FAIL rnd_counts @%0d: got e=%0d e2=%0d w=%0d want %0d/%0d/%0d",
                         i, err_count, err_count2, wrap_count, sat(m_errc, 255), sat(m_errc, 3), sat(m_wrapc, 255));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_hold_fault();
        test_sync_error();
        test_saturate_clear();
        test_reset_mid_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
